vga_timing_dither: RTL
======================

VGA_TIMING_DITHER -- requirements
Module: vga_timing_dither

Interface
REQ-001 SHALL have parameter H_DISPLAY, default 1220, active pixels per line.
REQ-002 SHALL have parameters H_FRONT_PORCH 31, H_SYNC_PULSE 183, H_BACK_PORCH 91; H_TOTAL derived as the sum of all four H parameters (1525).
REQ-003 SHALL have parameters V_DISPLAY 480, V_FRONT_PORCH 10, V_SYNC_PULSE 2, V_BACK_PORCH 33; V_TOTAL derived as their sum (525).
REQ-004 SHALL have parameter IN_BITS, default 6, colour input width per channel.
REQ-005 SHALL have parameter OUT_BITS, default 2, colour output width; D = IN_BITS-OUT_BITS, D even, 2..8.
REQ-006 SHALL have parameter PIX_LATENCY, default 0, range 0..7, cycles from counts to matching colour input.
REQ-007 SHALL have parameter SYNC_POL, default 0; 0 = sync pulses active-low, 1 = active-high.
REQ-008 SHALL have parameter FRAME_BITS, default 11, frame counter width.
REQ-009 SHALL have port clk48, input, 1 bit, sole clock.
REQ-010 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-011 SHALL have ports r_in, g_in, b_in, input, IN_BITS each, colour for counts issued PIX_LATENCY cycles earlier.
REQ-012 SHALL have port dither_en, input, 1 bit, 1 = ordered dither, 0 = truncate.
REQ-013 SHALL have port temporal_en, input, 1 bit, 1 = alternate Bayer phase on odd frames.
REQ-014 SHALL have ports h_count (11), v_count (10), frame (FRAME_BITS), outputs, undelayed counters.
REQ-015 SHALL have ports line_start and frame_start, outputs, 1 bit, one-cycle strobes.
REQ-016 SHALL have ports hsync, vsync, output, 1 bit, registered sync.
REQ-017 SHALL have ports r_out, g_out, b_out, output, OUT_BITS each, registered colour.

Function
REQ-018 SHALL increment h_count every cycle; h_count==H_TOTAL-1 wraps to 0 and advances v_count.
REQ-019 SHALL wrap v_count at V_TOTAL-1 to 0 and increment frame, frame wrapping modulo 2^FRAME_BITS.
REQ-020 SHALL assert line_start iff h_count==H_DISPLAY; frame_start iff h_count==0 and v_count==0.
REQ-021 SHALL compute raw hsync active for h_count in [H_DISPLAY+H_FRONT_PORCH, +H_SYNC_PULSE), vsync likewise on v_count; active = h_count<H_DISPLAY and v_count<V_DISPLAY.
REQ-022 SHALL delay {raw hsync, raw vsync, active, h_count[D/2-1:0], v_count[D/2-1:0], frame[0]} by a PIX_LATENCY-deep shift register (wire when 0).
REQ-023 SHALL register outputs one cycle after delay stage; total latency counts->hsync/vsync = PIX_LATENCY+1; colour input -> colour output = 1.
REQ-024 SHALL form Bayer threshold M (D bits): i = delayed x bits, bit 0 XORed with (temporal_en & delayed frame[0]); j = delayed y bits; a=i^j, b=j; M MSB-first = a[0],b[0],a[1],b[1],...
REQ-025 SHALL output, dither_en=1: q = (c + M) >> D, saturated to 2^OUT_BITS-1; dither_en=0: q = c >> D.
REQ-026 SHALL drive colour outputs 0 whenever delayed active is 0.
REQ-027 SHALL apply dither_en/temporal_en changes from the next cycle, no frame alignment.

Reset
REQ-028 SHALL, on rst sampled high, set h_count, v_count, frame to 0, clear delay line to inactive sync and active=0, colour outputs 0, hsync/vsync to inactive level (1 when SYNC_POL=0); frame_start is high in the first cycle after rst deasserts.
REQ-029 SHALL override all counting with rst mid-line/mid-frame; counting resumes from 0,0.

Verification (H 8/2/3/3 = 16, V 4/1/1/2 = 8, IN 6, OUT 2)
REQ-030 SHALL check: PIX_LATENCY=2, SYNC_POL=0 -> hsync low exactly 3 cycles, starting 3 cycles after h_count==10; line_start at h_count==8.
REQ-031 SHALL check: 128 cycles after reset -> frame==1, frame_start pulse, v_count==0; vsync low for v_count 5 (delayed).
REQ-032 SHALL check: c=40, dither_en=0 -> output 2 all active pixels; dither_en=1 -> (x0,y0)=2, (x1,y0)=3 (M=8), 4x4 block eight 3s, eight 2s.
REQ-033 SHALL check: c=63, dither_en=1, M=15 -> output 3 (saturation, no wrap to 0).
REQ-034 SHALL check: temporal_en=1, odd frame, c=40 -> (x0,y0)=3; even frame -> 2.
REQ-035 SHALL check: rst asserted at h_count=5, v_count=3 -> next cycle h_count=0, v_count=0, colour 0, syncs inactive.

Source files
------------

// File: rtl/vga_timing_dither.sv
// VGA raster timing generator with an ordered (4x4-style Bayer) colour dither and
// an optional per-frame phase flip; colour arrives PIX_LATENCY cycles after its counts.
module vga_timing_dither #(
    parameter int H_DISPLAY     = 1220,
    parameter int H_FRONT_PORCH = 31,
    parameter int H_SYNC_PULSE  = 183,
    parameter int H_BACK_PORCH  = 91,
    parameter int V_DISPLAY     = 480,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_SYNC_PULSE  = 2,
    parameter int V_BACK_PORCH  = 33,
    parameter int IN_BITS       = 6,
    parameter int OUT_BITS      = 2,
    parameter int PIX_LATENCY   = 0,
    parameter int SYNC_POL      = 0,
    parameter int FRAME_BITS    = 11
) (
    input  logic                  clk48,
    input  logic                  rst,
    input  logic [IN_BITS-1:0]    r_in,
    input  logic [IN_BITS-1:0]    g_in,
    input  logic [IN_BITS-1:0]    b_in,
    input  logic                  dither_en,
    input  logic                  temporal_en,
    output logic [10:0]           h_count,
    output logic [9:0]            v_count,
    output logic [FRAME_BITS-1:0] frame,
    output logic                  line_start,
    output logic                  frame_start,
    output logic                  hsync,
    output logic                  vsync,
    output logic [OUT_BITS-1:0]   r_out,
    output logic [OUT_BITS-1:0]   g_out,
    output logic [OUT_BITS-1:0]   b_out
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
    localparam int D       = IN_BITS - OUT_BITS;
    localparam int HB      = D / 2;
    localparam int DW      = 2 * HB + 4;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_DISP   = 11'(H_DISPLAY);
    localparam logic [10:0] HS_START = 11'(H_DISPLAY + H_FRONT_PORCH);
    localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FRONT_PORCH + H_SYNC_PULSE);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_DISP   = 10'(V_DISPLAY);
    localparam logic [9:0]  VS_START = 10'(V_DISPLAY + V_FRONT_PORCH);
    localparam logic [9:0]  VS_END   = 10'(V_DISPLAY + V_FRONT_PORCH + V_SYNC_PULSE);
    localparam logic        POL      = (SYNC_POL != 0);

    logic [10:0]           h_q, h_d;
    logic [9:0]            v_q, v_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;

    always_comb begin
        h_d     = h_q + 11'd1;
        v_d     = v_q;
        frame_d = frame_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
                v_d     = '0;
                frame_d = frame_q + FRAME_BITS'(1);
            end else begin
                v_d = v_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk48) begin
        if (rst) begin
            h_q     <= '0;
            v_q     <= '0;
            frame_q <= '0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            frame_q <= frame_d;
        end
    end

    assign h_count     = h_q;
    assign v_count     = v_q;
    assign frame       = frame_q;
    assign line_start  = (h_q == H_DISP);
    assign frame_start = (h_q == '0) && (v_q == '0);

    // Delay line word: {hs_raw, vs_raw, active, x bits, y bits, frame[0]}; all-zero is idle.
    logic [DW-1:0] pipe_in, pipe_out;
    logic          hs_raw, vs_raw, act_raw;

    assign hs_raw  = (h_q >= HS_START) && (h_q < HS_END);
    assign vs_raw  = (v_q >= VS_START) && (v_q < VS_END);
    assign act_raw = (h_q < H_DISP) && (v_q < V_DISP);
    assign pipe_in = {hs_raw, vs_raw, act_raw, h_q[HB-1:0], v_q[HB-1:0], frame_q[0]};

    if (PIX_LATENCY == 0) begin : g_nodly
        assign pipe_out = pipe_in;
    end else begin : g_dly
        logic [DW-1:0] dly_q [PIX_LATENCY];
        always_ff @(posedge clk48) begin
            if (rst) begin
                for (int unsigned k = 0; k < PIX_LATENCY; k++) dly_q[k] <= '0;
            end else begin
                dly_q[0] <= pipe_in;
                for (int unsigned k = 1; k < PIX_LATENCY; k++) dly_q[k] <= dly_q[k-1];
            end
        end
        assign pipe_out = dly_q[PIX_LATENCY-1];
    end

    logic          hs_p, vs_p, act_p, fr_p;
    logic [HB-1:0] x_p, y_p, i_bits;
    logic [D-1:0]  m;

    assign hs_p  = pipe_out[DW-1];
    assign vs_p  = pipe_out[DW-2];
    assign act_p = pipe_out[DW-3];
    assign x_p   = pipe_out[2*HB:HB+1];
    assign y_p   = pipe_out[HB:1];
    assign fr_p  = pipe_out[0];

    // Threshold bits interleave MSB-first as a[0],b[0],a[1],b[1],... with a=i^j, b=j.
    always_comb begin
        i_bits    = x_p;
        i_bits[0] = x_p[0] ^ (temporal_en & fr_p);
        m         = '0;
        for (int unsigned k = 0; k < HB; k++) begin
            m[D-1-2*k] = i_bits[k] ^ y_p[k];
            m[D-2-2*k] = y_p[k];
        end
    end

    function automatic logic [OUT_BITS-1:0] quant(input logic [IN_BITS-1:0] c,
                                                  input logic [D-1:0]       thr,
                                                  input logic               dith);
        logic [IN_BITS:0]  sum;
        logic [OUT_BITS:0] q;
        sum = {1'b0, c} + (dith ? {{(IN_BITS+1-D){1'b0}}, thr} : '0);
        q   = sum[IN_BITS:D];
        return q[OUT_BITS] ? '1 : q[OUT_BITS-1:0];
    endfunction

    logic                hs_q, hs_d, vs_q, vs_d;
    logic [OUT_BITS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

    always_comb begin
        hs_d = POL ? hs_p : ~hs_p;
        vs_d = POL ? vs_p : ~vs_p;
        r_d  = '0;
        g_d  = '0;
        b_d  = '0;
        if (act_p) begin
            r_d = quant(r_in, m, dither_en);
            g_d = quant(g_in, m, dither_en);
            b_d = quant(b_in, m, dither_en);
        end
    end

    always_ff @(posedge clk48) begin
        if (rst) begin
            hs_q <= ~POL;
            vs_q <= ~POL;
            r_q  <= '0;
            g_q  <= '0;
            b_q  <= '0;
        end else begin
            hs_q <= hs_d;
            vs_q <= vs_d;
            r_q  <= r_d;
            g_q  <= g_d;
            b_q  <= b_d;
        end
    end

    assign hsync = hs_q;
    assign vsync = vs_q;
    assign r_out = r_q;
    assign g_out = g_q;
    assign b_out = b_q;
endmodule
